// File: rtl/serial_pattern_pkg.sv
// Shared state codes for the serial pattern transmitter.
package serial_pattern_pkg;

   localparam int unsigned STATE_W = 2;

   localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
   localparam logic [STATE_W-1:0] ST_SEND = 2'd1;
   localparam logic [STATE_W-1:0] ST_GAP  = 2'd2;
   localparam logic [STATE_W-1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/serial_pattern_tx_pattern_shifter.sv
// Parallel-load left shifter; load aligns pattern[length-1] to the MSB tap.
module pattern_shifter #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned LEN_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] pattern,
   input  logic [LEN_W-1:0] length,
   output logic             tap
);

   logic [WIDTH-1:0] sr_q;
   logic [LEN_W-1:0] align;

   // length is already clamped to 1..WIDTH by the caller
   assign align = LEN_W'(WIDTH) - length;

   // Load takes priority over shift; zeros fill from the right
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sr_q <= '0;
      end else if (load) begin
         sr_q <= pattern << align;
      end else if (shift) begin
         sr_q <= {sr_q[WIDTH-2:0], 1'b0};
      end
   end

   assign tap = sr_q[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: repeats an MSB-first frame with idle gaps.
module serial_pattern_tx
   import serial_pattern_pkg::*;
#(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned CNT_W = 4,
   parameter  int unsigned GAP   = 2,
   localparam int unsigned LEN_W = $clog2(WIDTH + 1)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   pattern,
   input  logic [LEN_W-1:0]   length,
   input  logic [CNT_W-1:0]   repeat_cnt,
   input  logic               abort,
   output logic               bit_out,
   output logic               bit_valid,
   output logic               busy,
   output logic               done,
   output logic [STATE_W-1:0] state
);

   localparam int unsigned GAP_W = (GAP < 1) ? 1 : $clog2(GAP + 1);

   logic [STATE_W-1:0] state_q, state_d;
   logic [WIDTH-1:0]   pat_q;
   logic [LEN_W-1:0]   len_q;
   logic [CNT_W-1:0]   frame_q;
   logic [LEN_W-1:0]   bit_cnt_q;
   logic [GAP_W-1:0]   gap_q;

   logic               sh_load, sh_shift, tap;
   logic [LEN_W-1:0]   eff_len_in, load_len;
   logic [WIDTH-1:0]   load_pat;
   logic               last_bit, frames_left;

   // Out-of-range lengths mean a full-width frame
   assign eff_len_in  = ((length == '0) || (length > LEN_W'(WIDTH))) ? LEN_W'(WIDTH) : length;
   // The first load comes straight from the ports; reloads use the latched copy
   assign load_pat    = (state_q == ST_IDLE) ? pattern : pat_q;
   assign load_len    = (state_q == ST_IDLE) ? eff_len_in : len_q;
   assign last_bit    = (bit_cnt_q == LEN_W'(1));
   assign frames_left = (frame_q > CNT_W'(1));

   pattern_shifter #(
      .WIDTH (WIDTH),
      .LEN_W (LEN_W)
   ) u_shifter (
      .clock   (clock),
      .reset   (reset),
      .load    (sh_load),
      .shift   (sh_shift),
      .pattern (load_pat),
      .length  (load_len),
      .tap     (tap)
   );

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and shifter control; abort wins over every other transition
   always_comb begin
      state_d  = state_q;
      sh_load  = 1'b0;
      sh_shift = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (repeat_cnt == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_SEND;
                  sh_load = 1'b1;
               end
            end
         end
         ST_SEND: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (last_bit) begin
               if (!frames_left) begin
                  state_d = ST_DONE;
               end else if (GAP == 0) begin
                  sh_load = 1'b1;
               end else begin
                  state_d = ST_GAP;
               end
            end else begin
               sh_shift = 1'b1;
            end
         end
         ST_GAP: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (gap_q == GAP_W'(1)) begin
               state_d = ST_SEND;
               sh_load = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Operation latches and the bit, frame and gap counters
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pat_q     <= '0;
         len_q     <= '0;
         frame_q   <= '0;
         bit_cnt_q <= '0;
         gap_q     <= '0;
      end else begin
         if ((state_q == ST_IDLE) && start) begin
            pat_q   <= pattern;
            len_q   <= eff_len_in;
            frame_q <= repeat_cnt;
         end else if ((state_q == ST_SEND) && !abort && last_bit) begin
            frame_q <= frame_q - CNT_W'(1);
         end

         if (sh_load) begin
            bit_cnt_q <= load_len;
         end else if ((state_q == ST_SEND) && (bit_cnt_q != '0)) begin
            bit_cnt_q <= bit_cnt_q - LEN_W'(1);
         end

         if ((state_q == ST_SEND) && (state_d == ST_GAP)) begin
            gap_q <= GAP_W'(GAP);
         end else if ((state_q == ST_GAP) && (gap_q != '0)) begin
            gap_q <= gap_q - GAP_W'(1);
         end
      end
   end

   // Outputs decoded from registered state only
   always_comb begin
      bit_valid = (state_q == ST_SEND);
      bit_out   = (state_q == ST_SEND) & tap;
      busy      = (state_q != ST_IDLE);
      done      = (state_q == ST_DONE);
      state     = state_q;
   end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Testbench for serial_pattern_tx: table vectors, corner sequences, random ops.
module tb_serial_pattern_tx;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;
   localparam int GAP   = 2;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic       abort;
   logic [7:0] pattern;
   logic [3:0] length;
   logic [3:0] repeat_cnt;
   logic       bit_out, bit_valid, busy, done;
   logic [1:0] state;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic v;
      logic b;
      logic bz;
      logic d;
   } obs_t;

   typedef struct {
      logic [7:0]  p;
      logic [3:0]  l;
      logic [3:0]  r;
      int          cycles;
      logic [63:0] stream;
      int          nbits;
      int          det;
   } vec_t;

   obs_t obs_q[$];
   obs_t exp_q[$];
   vec_t vecs[8];

   always #5 clock = ~clock;

   serial_pattern_tx #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W),
      .GAP   (GAP)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .pattern    (pattern),
      .length     (length),
      .repeat_cnt (repeat_cnt),
      .abort      (abort),
      .bit_out    (bit_out),
      .bit_valid  (bit_valid),
      .busy       (busy),
      .done       (done),
      .state      (state)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Start one operation and record every busy cycle until IDLE returns
   task automatic run_op(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                         input bit scramble);
      bit timed_out;
      @(negedge clock);
      pattern    = p;
      length     = l;
      repeat_cnt = r;
      start      = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      obs_q.delete();
      timed_out = 1'b1;
      for (int c = 0; c < 400; c++) begin
         @(negedge clock);
         if (!busy) begin
            timed_out = 1'b0;
            break;
         end
         obs_q.push_back('{bit_valid, bit_out, busy, done});
         if (scramble) begin
            pattern    = 8'($urandom);
            length     = 4'($urandom);
            repeat_cnt = 4'($urandom);
            start      = 1'($urandom);
         end
      end
      start = 1'b0;
      check("op_timeout", 64'(timed_out), 64'd0);
   endtask

   // Expected cycle-by-cycle trace built directly from the frame rules
   function automatic void build_model(input logic [7:0] p, input int l, input int r);
      int len;
      len = (l == 0 || l > WIDTH) ? WIDTH : l;
      exp_q.delete();
      for (int f = 0; f < r; f++) begin
         for (int i = len - 1; i >= 0; i--) exp_q.push_back('{1'b1, p[i], 1'b1, 1'b0});
         if (f < r - 1) begin
            for (int g = 0; g < GAP; g++) exp_q.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
         end
      end
      exp_q.push_back('{1'b0, 1'b0, 1'b1, 1'b1});
   endfunction

   task automatic compare_model(input string name);
      int first;
      int n;
      check({name, "_cycles"}, 64'(obs_q.size()), 64'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      first = -1;
      for (int i = 0; i < n; i++) begin
         if (obs_q[i] !== exp_q[i]) begin
            first = i;
            break;
         end
      end
      tests++;
      if (first >= 0) begin
         fails++;
         $display("FAIL %s_trace cycle %0d: got valid/bit/busy/done %b expected %b",
                  name, first + 1, obs_q[first], exp_q[first]);
      end
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [63:0] stream;
      int          nbits, ndone, det, vcount;
      logic        prev, done_last;

      reset = 1'b1; start = 1'b0; abort = 1'b0;
      pattern = '0; length = '0; repeat_cnt = '0;
      #1;
      check("reset_outputs", 64'({bit_out, bit_valid, busy, done, state}), 64'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("reset_idle", 64'({bit_out, bit_valid, busy, done, state}), 64'd0);

      vecs[0] = '{8'h0D, 4'd4,  4'd1,  5,  64'hD,    4,  1};
      vecs[1] = '{8'h0F, 4'd4,  4'd3,  17, 64'hFFF,  12, 1};
      vecs[2] = '{8'hA5, 4'd0,  4'd1,  9,  64'hA5,   8,  99};
      vecs[3] = '{8'hA5, 4'd0,  4'd0,  1,  64'h0,    0,  99};
      vecs[4] = '{8'hFF, 4'd3,  4'd2,  9,  64'h3F,   6,  1};
      vecs[5] = '{8'h0D, 4'd12, 4'd1,  9,  64'h0D,   8,  5};
      vecs[6] = '{8'h3C, 4'd1,  4'd15, 44, 64'h0,    15, 99};
      vecs[7] = '{8'h0A, 4'd4,  4'd2,  11, 64'hAA,   8,  99};

      for (int k = 0; k < 8; k++) begin
         run_op(vecs[k].p, vecs[k].l, vecs[k].r, 1'b0);
         stream = '0; nbits = 0; ndone = 0; det = 99; prev = 1'b0;
         foreach (obs_q[i]) begin
            if (obs_q[i].v) begin
               stream = {stream[62:0], obs_q[i].b};
               if (prev && obs_q[i].b && det == 99) det = nbits;
               prev = obs_q[i].b;
               nbits++;
            end
            if (obs_q[i].d) ndone++;
         end
         done_last = (ndone == 1) && (obs_q.size() > 0) && obs_q[obs_q.size() - 1].d;
         check($sformatf("vec%0d_busy_cycles", k), 64'(obs_q.size()), 64'(vecs[k].cycles));
         check($sformatf("vec%0d_stream", k), stream, vecs[k].stream);
         check($sformatf("vec%0d_nbits", k), 64'(nbits), 64'(vecs[k].nbits));
         check($sformatf("vec%0d_done_last", k), 64'(done_last), 64'd1);
         check($sformatf("vec%0d_detect", k), 64'(det), 64'(vecs[k].det));
         check($sformatf("vec%0d_idle_after", k), 64'(state), 64'd0);
      end

      // Abort during the second bit of frame 2
      @(negedge clock);
      pattern = 8'h0F; length = 4'd4; repeat_cnt = 4'd3; start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      ndone = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         if (done) ndone++;
      end
      check("abort_pre_valid", 64'(bit_valid), 64'd1);
      abort = 1'b1;
      @(posedge clock);
      #1;
      abort = 1'b0;
      @(negedge clock);
      if (done) ndone++;
      check("abort_idle", 64'({bit_valid, busy, done, state}), 64'd0);
      check("abort_no_done", 64'(ndone), 64'd0);
      run_op(8'h0D, 4'd4, 4'd1, 1'b0);
      build_model(8'h0D, 4, 1);
      compare_model("after_abort");

      // Asynchronous reset between edges mid-frame
      @(negedge clock);
      pattern = 8'hA5; length = 4'd8; repeat_cnt = 4'd2; start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (3) @(negedge clock);
      check("reset_pre_busy", 64'({bit_valid, busy}), 64'b11);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_outputs", 64'({bit_out, bit_valid, busy, done, state}), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      vcount = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         if (bit_valid || busy) vcount++;
      end
      check("after_reset_silent", 64'(vcount), 64'd0);

      // Random operations with input scrambling while busy
      for (int t = 0; t < 25; t++) begin
         logic [7:0] rp;
         logic [3:0] rl, rr;
         rp = 8'($urandom);
         rl = 4'($urandom);
         rr = 4'($urandom_range(0, (t % 5 == 0) ? 15 : 4));
         run_op(rp, rl, rr, 1'b1);
         build_model(rp, int'(rl), int'(rr));
         compare_model($sformatf("rand%0d", t));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial pattern transmitter: the driving end of our serial sequence-detector path. It latches an up-to-WIDTH-bit pattern and shifts it out MSB-first, one bit per clock, on a single-bit line, repeating the frame a programmable number of times with idle gaps between frames. On the board it feeds the detector's serial input, so a detector can be exercised from switches without hand-clocking each bit.

## Interface
- WIDTH, 8: maximum pattern length in bits.
- CNT_W, 4: width of the repeat count.
- GAP, 2: idle cycles inserted between repeated frames (0 allowed).
- LEN_W, $clog2(WIDTH+1): width of the length port (derived, not overridden).
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE immediately.
- start  in  1  request; sampled only in IDLE.
- pattern  in  WIDTH  bits to send; pattern[length-1] is sent first, pattern[0] last.
- length  in  LEN_W  bits per frame, 1..WIDTH; 0 or >WIDTH means WIDTH.
- repeat_cnt  in  CNT_W  number of frames; 0 means no frames.
- abort  in  1  cancels an operation in progress.
- bit_out  out  1  serial data; 0 whenever bit_valid=0.
- bit_valid  out  1  bit_out carries a pattern bit this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on normal completion.
- state  out  2  current state code, for LEDR debug display.

## Operation
- States: IDLE=0, SEND=1, GAP=2, DONE=3.
- IDLE: if start=1, latch pattern, effective length and repeat_cnt. If repeat_cnt=0, go to DONE; otherwise load the shifter, set the bit counter to the effective length and the frame counter to repeat_cnt, then go to SEND.
- SEND: bit_valid=1 and bit_out=current MSB of the loaded window. Each cycle, shift and decrement the bit counter. After the last bit, decrement the frame counter. If frames remain, go to GAP (or reload and stay in SEND when GAP=0); otherwise go to DONE.
- GAP: bit_valid=0 and bit_out=0 for exactly GAP cycles. Then reload the shifter from the latched pattern and go to SEND.
- DONE: done=1 for one cycle, then IDLE.
- abort=1 in SEND, GAP or DONE: go to IDLE on the next edge, with no done pulse. abort has priority over every other transition, and is ignored in IDLE.
- start while busy is ignored. Changes to pattern, length or repeat_cnt after latching have no effect on the operation in progress.
- Counters never wrap. The maximum repeat_cnt (2^CNT_W−1) completes exactly that many frames.

## Timing
- Reset values: state=IDLE, bit_out=0, bit_valid=0, busy=0, done=0, all counters 0.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- Start accepted at edge k: first bit valid in cycle k+1, and busy rises in the same cycle.
- Total busy cycles = L·R + GAP·(R−1) + 1, where L is the effective length and R is repeat_cnt ≥ 1. When R=0, busy lasts 1 cycle (DONE only).
- done is high in the final busy cycle. IDLE follows, and a new start is accepted at that next edge.
- Asserting reset mid-frame clears the outputs asynchronously. No further bits are emitted until a fresh start.

## Structure
- Package serial_pattern_pkg: state localparams (IDLE, SEND, GAP, DONE) and the 2-bit state width.
- One sub-module, pattern_shifter: a WIDTH-bit parallel-load, left-shift register with load and shift enables. It outputs the bit at the current window MSB, with the load aligning pattern[length-1] to the output tap.
- The top level holds the FSM, the bit, frame and gap counters, and the output decode.

## Test plan
- pattern=8'h0D, length=4, repeat=1, GAP=2: bits 1,1,0,1 valid in cycles 1–4; done in cycle 5; busy for 5 cycles.
- pattern=8'h0F, length=4, repeat=3: three frames of 1,1,1,1, each separated by 2 invalid zero cycles; done in cycle 17.
- length=0, pattern=8'hA5, repeat=1: 8 bits 1,0,1,0,0,1,0,1; done in cycle 9. repeat=0: no valid bits; done in cycle 1 only.
- abort asserted during the 2nd bit of frame 2: IDLE next cycle, no done pulse, bit_valid=0. A start on the following cycle begins a clean frame.
- Async reset pulse between clock edges mid-frame: outputs go to 0 immediately. start pulses and pattern changes while busy do not alter the stream.
- Loopback to the sequence detector: 1,1,0,1 and 1,1,1,1 streams raise the detector output on the expected bit; a 1,0,1,0 stream never raises it.
